// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU operand dispatch path.
//   OP_ADD/OP_MUL/OP_DIV/OP_SUB : opcode constants (channel index = opcode)
//   operand_pair_t              : {a, b} operand pair at the default FPU width
package fpu_pkg;

  localparam int FPU_WIDTH = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_DIV = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;

  typedef struct packed {
    logic [FPU_WIDTH-1:0] a;
    logic [FPU_WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/fpu_op_fifo.sv
// fpu_op_fifo: single-clock synchronous FIFO of operand pairs.
// Ports:
//   clk, rst_n  : clock, async active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   full, empty : occupancy flags, derived from the registered count
//   head        : oldest entry (undefined content when empty; caller masks)
module fpu_op_fifo
  import fpu_pkg::*;
#(
  parameter type T     = operand_pair_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO's head is masked by the caller.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_op_dispatch.sv
// fpu_op_dispatch: registered operand dispatcher. Routes each accepted
// {a, b, operation} request into the FIFO of channel `operation`.
// Opcodes >= N_CH are accepted, discarded and flagged on illegal_op.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   a, b, operation     : request payload and opcode
//   in_valid / in_ready : request handshake (in_ready depends only on
//                         operation and registered FIFO counts)
//   ch_a, ch_b          : per-channel head operands, channel i at [i*WIDTH +: WIDTH]
//   ch_valid / ch_ready : per-channel head handshake
//   illegal_op          : one-cycle pulse after an accepted illegal opcode
// Build option: FPU_DISPATCH_HIZ_EN drives 'z on empty channel slices
// instead of 0 (legacy shared-bus tie-in).
module fpu_op_dispatch
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int N_CH  = 4,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [OP_W-1:0]       operation,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] ch_a,
  output logic [N_CH*WIDTH-1:0] ch_b,
  output logic [N_CH-1:0]       ch_valid,
  input  logic [N_CH-1:0]       ch_ready,
  output logic                  illegal_op
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  localparam logic [OP_W:0] NCH_C = (OP_W+1)'(N_CH);

  logic            legal;
  logic            tgt_full;
  logic            accept;
  logic [N_CH-1:0] full;
  logic [N_CH-1:0] empty;
  pair_t           head [N_CH];

  // Extra top bit keeps the compare correct when N_CH == 2**OP_W.
  assign legal = ({1'b0, operation} < NCH_C);

  always_comb begin
    tgt_full = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if ({1'b0, operation} == (OP_W+1)'(i)) tgt_full = full[i];
    end
  end

  assign in_ready = legal ? !tgt_full : 1'b1;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic push_i;
    assign push_i = accept && legal && ({1'b0, operation} == (OP_W+1)'(i));

    fpu_op_fifo #(
      .T     (pair_t),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_i),
      .push_data ('{a: a, b: b}),
      .pop       (ch_ready[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );

    assign ch_valid[i] = !empty[i];
`ifdef FPU_DISPATCH_HIZ_EN
    assign ch_a[i*WIDTH +: WIDTH] = empty[i] ? {WIDTH{1'bz}} : head[i].a;
    assign ch_b[i*WIDTH +: WIDTH] = empty[i] ? {WIDTH{1'bz}} : head[i].b;
`else
    assign ch_a[i*WIDTH +: WIDTH] = empty[i] ? '0 : head[i].a;
    assign ch_b[i*WIDTH +: WIDTH] = empty[i] ? '0 : head[i].b;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op <= 1'b0;
    else        illegal_op <= accept && !legal;
  end

endmodule

// File: tb/tb_fpu_op_dispatch.sv
module tb_fpu_op_dispatch;
  import fpu_pkg::*;

  localparam int WIDTH = 32;
  localparam int N_CH  = 4;

  logic                  clk;
  logic                  rst_n;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [3:0]            operation;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*WIDTH-1:0] ch_a;
  logic [N_CH*WIDTH-1:0] ch_b;
  logic [N_CH-1:0]       ch_valid;
  logic [N_CH-1:0]       ch_ready;
  logic                  illegal_op;

  int vectors;
  int miscompares;

  fpu_op_dispatch #(.WIDTH(WIDTH), .OP_W(4), .N_CH(N_CH), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .operation  (operation),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ch_a       (ch_a),
    .ch_b       (ch_b),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hiz_exp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    operation = OP_MUL;
    in_valid  = 1'b0;
    ch_ready  = '0;
    step();
    step();

    // Reset state
    check("rst_ch_valid", 128'(ch_valid), 128'h0);
    check("rst_ch_a", 128'(ch_a), 128'h0);
    check("rst_ch_b", 128'(ch_b), 128'h0);
    check("rst_illegal", 128'(illegal_op), 128'h0);
    check("rst_in_ready_op1", 128'(in_ready), 128'h1);

    // First request to channel 1
    rst_n     = 1'b1;
    step();
    a         = 32'h3F80_0000;
    b         = 32'h4000_0000;
    operation = OP_MUL;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    check("op1_ch_valid", 128'(ch_valid), 128'h2);
    check("op1_ch1_a", 128'(ch_a[63:32]), 128'h3F80_0000);
    check("op1_ch1_b", 128'(ch_b[63:32]), 128'h4000_0000);
    check("op1_ch0_a_zero", 128'(ch_a[31:0]), 128'h0);
    ch_ready = 4'b0010;
    step();
    ch_ready = '0;
    check("op1_popped", 128'(ch_valid), 128'h0);

    // Fill channel 2 (DEPTH=2)
    operation = OP_DIV;
    in_valid  = 1'b1;
    a = 32'hA1; b = 32'hB1;
    #1 check("fill1_ready", 128'(in_ready), 128'h1);
    step();
    a = 32'hA2; b = 32'hB2;
    check("fill2_ready", 128'(in_ready), 128'h1);
    step();
    a = 32'hA3; b = 32'hB3;
    #1 check("fill3_not_ready", 128'(in_ready), 128'h0);
    check("fill_ch_valid", 128'(ch_valid), 128'h4);
    ch_ready = 4'b0100;
    #1 check("full_pop_no_ready", 128'(in_ready), 128'h0);
    check("full_head_a1", 128'(ch_a[95:64]), 128'hA1);
    step();
    ch_ready = '0;
    check("after_pop_ready", 128'(in_ready), 128'h1);
    check("after_pop_head_a2", 128'(ch_a[95:64]), 128'hA2);
    check("after_pop_head_b2", 128'(ch_b[95:64]), 128'hB2);
    step();
    in_valid = 1'b0;
    check("refill_not_ready", 128'(in_ready), 128'h0);
    ch_ready = 4'b0100;
    step();
    check("drain_head_a3", 128'(ch_a[95:64]), 128'hA3);
    step();
    ch_ready = '0;
    check("drain_empty", 128'(ch_valid), 128'h0);
    check("drain_slice_zero", 128'(ch_a[95:64]), 128'h0);

    // Simultaneous push/pop on channel 0
    operation = OP_ADD;
    a = 32'hAA; b = 32'hBB;
    in_valid = 1'b1;
    step();
    a = 32'h1; b = 32'h2;
    ch_ready = 4'b0001;
    #1 check("pp_ready", 128'(in_ready), 128'h1);
    step();
    in_valid = 1'b0;
    ch_ready = '0;
    check("pp_valid", 128'(ch_valid), 128'h1);
    check("pp_head_a", 128'(ch_a[31:0]), 128'h1);
    check("pp_head_b", 128'(ch_b[31:0]), 128'h2);
    ch_ready = 4'b0001;
    step();
    ch_ready = '0;
    check("pp_count_one", 128'(ch_valid), 128'h0);

    // Illegal opcode
    operation = 4'd9;
    a = 32'hDEAD; b = 32'hBEEF;
    in_valid = 1'b1;
    #1 check("ill_ready", 128'(in_ready), 128'h1);
    check("ill_no_pulse_yet", 128'(illegal_op), 128'h0);
    step();
    in_valid = 1'b0;
    check("ill_pulse", 128'(illegal_op), 128'h1);
    check("ill_no_valid", 128'(ch_valid), 128'h0);
    step();
    check("ill_pulse_end", 128'(illegal_op), 128'h0);

    // Reset mid-operation
    in_valid = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      operation = 4'(i);
      a = 32'h100 + 32'(i);
      b = 32'h200 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    check("all_valid", 128'(ch_valid), 128'hF);
    check("ch3_a", 128'(ch_a[127:96]), 128'h103);
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", 128'(ch_valid), 128'h0);
    check("async_rst_a", 128'(ch_a), 128'h0);
    #1 rst_n = 1'b1;
    step();
    step();
    check("post_rst_valid", 128'(ch_valid), 128'h0);
    check("post_rst_b", 128'(ch_b), 128'h0);

    // Empty channel 3 slice per build option
`ifdef FPU_DISPATCH_HIZ_EN
    hiz_exp = {32{1'bz}};
`else
    hiz_exp = 32'h0;
`endif
    check("empty_ch3_a", 128'(ch_a[127:96]), 128'(hiz_exp));
    check("empty_ch3_b", 128'(ch_b[127:96]), 128'(hiz_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_op_dispatch.md
# fpu_op_dispatch

Registered operand dispatcher for the floating-point unit: accepts one `{a, b, operation}` request per cycle and routes it to the operand FIFO of the arithmetic unit selected by `operation`. It is a parametrised successor to the per-unit combinational operand gates. It adds per-channel buffering, a valid/ready handshake on both sides and illegal-opcode detection. It sits between the FPU front-end decoder and the add/mul/div/sub datapaths.

## Interface
Parameters:
- `WIDTH`, 32: operand width in bits.
- `OP_W`, 4: opcode width.
- `N_CH`, 4: number of output channels; channel `i` serves opcode `i`.
- `DEPTH`, 2: entries per channel FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; single clock domain, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `operation`  in  OP_W  opcode.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `ch_a`  out  N_CH*WIDTH  head operand A per channel; channel `i` at `[i*WIDTH +: WIDTH]`.
- `ch_b`  out  N_CH*WIDTH  head operand B per channel, same packing.
- `ch_valid`  out  N_CH  channel head valid.
- `ch_ready`  in  N_CH  consumer pops channel head.
- `illegal_op`  out  1  one-cycle pulse after an accepted opcode ≥ N_CH.

## Operation
- Target channel is `operation`. An opcode ≥ N_CH is illegal.
- `in_ready` is combinational: the target FIFO is not full. For an illegal opcode, `in_ready` is 1.
- Legal accepted request: `{a, b}` is pushed into FIFO[`operation`]. No other channel is affected.
- Illegal accepted request: the data is discarded and `illegal_op` is 1 on the following cycle only.
- Channel `i` pops its head when `ch_valid[i] && ch_ready[i]`. Channels pop independently; any subset may pop in the same cycle.
- Push and pop on the same channel in the same cycle: the occupancy count is unchanged and ordering is preserved (FIFO order).
- Full channel: `in_ready` is 0 for that opcode. A pop in the same cycle does not raise `in_ready` (no combinational ready→ready path).
- Empty channel: `ch_valid[i]` is 0 and `ch_a`/`ch_b` slice is 0, unless the macro below is defined.
- Pointers wrap modulo DEPTH. The count is `$clog2(DEPTH)+1` bits wide.
- Reset, including reset mid-transfer: all FIFOs are emptied, pointers are set to 0, `ch_valid` is 0, `ch_a`/`ch_b` are 0 and `illegal_op` is 0. Contents are lost.

## Timing
- Request accepted at edge N → `ch_valid[i]` is 1 after edge N (visible in cycle N+1). Data is registered and there is no input-to-output combinational path.
- Throughput: 1 request/cycle aggregate, and 1 pop/cycle per channel.
- `in_ready` depends only on `operation` and registered counts.
- `illegal_op` is registered: high for exactly cycle N+1.
- Back-to-back requests to one channel fill it in DEPTH cycles when there are no pops.

## Configuration
- `FPU_DISPATCH_HIZ_EN` defined: the `ch_a`/`ch_b` slices of an empty channel drive `'z`. This is for legacy shared-bus tie-in.
- Not defined: empty slices drive 0, and the block contains no tri-state logic. This is the default for synthesis.
- The macro has no effect on `ch_valid`, handshakes or `illegal_op`.

## Structure
- Shared package `fpu_pkg`:
  - opcode constants `OP_ADD=0`, `OP_MUL=1`, `OP_DIV=2`, `OP_SUB=3`;
  - typedef `operand_pair_t` (`{a, b}` of WIDTH each).
- Sub-module `fpu_op_fifo`: a single synchronous FIFO of `operand_pair_t`, with push/pop/full/empty/head. The top level instantiates N_CH copies with a generate loop and adds the opcode decode and illegal-op logic.

## Test plan
- Reset:
  - Hold `rst_n`=0 → all outputs are 0 and `in_ready`=1 for opcode 1.
  - Release, then one request `a=32'h3F800000`, `b=32'h40000000`, op=1 → cycle+1: `ch_valid=4'b0010`, channel 1 holds those values.
- Fill/full:
  - Three op=2 requests with `ch_ready=0`, DEPTH=2 → first two accepted.
  - Third sees `in_ready=0`.
  - Assert `ch_ready[2]` → head pops, `in_ready` returns 1 next cycle and FIFO order is preserved.
- Simultaneous push/pop: channel 0 holds 1 entry; push `a=32'h1` and pop in the same cycle → count stays 1 and the new head is `32'h1`.
- Illegal opcode: op=4'd9 with `in_valid` → accepted, `illegal_op` pulses for 1 cycle and no `ch_valid` changes.
- Reset mid-operation: all channels non-empty, pulse `rst_n` low asynchronously between edges → `ch_valid` goes to 0 immediately and stays 0 after release.
- Macro build: with `FPU_DISPATCH_HIZ_EN`, an empty channel 3 slice reads `'z`; without it, the slice reads 0.
